sl_wb_trace_mon: RTL and testbench
==================================

Name: sl_wb_trace_mon

Overview:
Synthesizable, parametrised Wishbone bus monitor for the Selen system bench and FPGA debug builds.
- Passively snoops one classic Wishbone slave port.
- Checks protocol and watchdog timeouts.
- Keeps per-type transaction counters and detects the test-finish write.
- Captures completed transactions, with timestamp and latency, into a drainable trace FIFO.
- Attaches beside any peripheral such as the SPI or ROM slave, in place of a simulation-only tracer.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; SEL_W = DATA_W/8
DEPTH, 16, trace FIFO entries; power of two, >= 2
TS_W, 32, timestamp counter width
LAT_W, 8, latency field width; latency saturates at all-ones
CNT_W, 16, width of event counters
TIMEOUT, 255, pending-request cycles before timeout; 1..2^LAT_W-1
FINISH_ADDR, 32'hFFFF_FFF0, write to this address raises finish

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
clr  in  1  sync clear of counters and sticky flags; FIFO untouched
wb_cyc  in  1  snooped cycle
wb_stb  in  1  snooped strobe
wb_we  in  1  snooped write enable
wb_sel  in  SEL_W  snooped byte select
wb_adr  in  ADDR_W  snooped address
wb_dat_w  in  DATA_W  master-to-slave data
wb_dat_r  in  DATA_W  slave-to-master data
wb_ack  in  1  snooped ack
wb_err  in  1  snooped err
tr_valid  out  1  trace head valid
tr_ready  in  1  trace consumer pop
tr_adr  out  ADDR_W  head address
tr_data  out  DATA_W  head data: dat_w for writes, dat_r for reads
tr_we / tr_sel / tr_err  out  1 / SEL_W / 1  head attributes
tr_ts  out  TS_W  head start timestamp
tr_lat  out  LAT_W  head latency in cycles (start to ack)
rd_cnt, wr_cnt, err_cnt, drop_cnt  out  CNT_W each  saturating counters
proto_err  out  1  sticky protocol violation
timeout_err  out  1  sticky watchdog expiry
finish  out  1  sticky test-finish flag
finish_data  out  DATA_W  data of the finishing write

Behaviour:
Reset (rst == 0 at posedge):
- All outputs 0, FIFO empty, timestamp 0, FSM IDLE.
- Reset mid-transaction discards the pending request; no entry is written.

Definitions:
- Free-running ts counter increments every cycle and wraps silently.
- req = wb_cyc & wb_stb.
- done = req & (wb_ack | wb_err).

FSM states IDLE, PEND, TOUT:
- IDLE:
  - req & !done: latch adr/we/sel/dat_w, start ts, lat=1; go to PEND.
  - done: zero-wait transaction, lat=0, start ts = current ts; stay IDLE.
- PEND:
  - lat increments each cycle, saturating.
  - done: complete; go to IDLE.
  - req dropped without ack: proto_err; go to IDLE; nothing logged.
  - lat reaches TIMEOUT: timeout_err; go to TOUT.
- TOUT: wait for !req, then go to IDLE. A late ack in TOUT is logged with tr_err=1 and lat saturated.

Protocol checks (each sets proto_err):
- wb_stb & !wb_cyc.
- ack or err without req.
- wb_ack & wb_err in the same cycle (the transaction is still logged, as err).
- adr/we/sel/dat_w changing in PEND versus the latched copies.

Completion cycle:
- Bump rd_cnt or wr_cnt; bump err_cnt on wb_err.
- Push the entry; it is visible at tr_valid on the next cycle.
- A write with adr == FINISH_ADDR sets finish and captures finish_data. A later finish write overwrites finish_data.

FIFO:
- Push is accepted if not full, or if a pop occurs in the same cycle.
- Otherwise the entry is dropped and drop_cnt increments.
- Pop on tr_valid & tr_ready; tr_ready while empty has no effect.
- Head outputs are stable while tr_valid & !tr_ready.

Counters:
- Saturate at all-ones and never wrap.
- clr has priority over a same-cycle increment; the result is 0.

Decomposition:
- Package sl_wb_mon_pkg holds:
  - state enum (IDLE, PEND, TOUT);
  - trace entry struct (adr, data, we, sel, err, ts, lat), parametrised via localparams in the module;
  - a saturating-increment function.
- Sub-module sl_sync_fifo, parametrised by width and depth:
  - show-ahead read;
  - full/empty from pointers with an extra wrap bit;
  - simultaneous push and pop when full is legal.
- The monitor instantiates it with the packed entry width.

Test Plan:
- Read 0x100, ack 3 cycles after stb, tr_ready=1 -> one entry: we=0, lat=3, data=dat_r; rd_cnt=1; no errors.
- Zero-wait write of 0xDEAD to FINISH_ADDR -> finish=1, finish_data=0xDEAD, wr_cnt=1, entry lat=0.
- 20 zero-wait writes with tr_ready=0 and DEPTH=16 -> 16 entries held, drop_cnt=4. Drain order matches addresses 0..15 with ascending ts.
- stb held 255 cycles with no ack (TIMEOUT=255) -> timeout_err at cycle 255. A late ack logs tr_err=1, lat=255.
- Address changes while in PEND, plus a stray ack with cyc=0 -> proto_err=1. clr returns proto_err and all counters to 0, FIFO contents unchanged.
- rst low mid-PEND for 2 cycles, then a new read -> no stale entry; first entry is the new read; counters restart from 0.

Source files
------------

// File: rtl/sl_wb_mon_pkg.sv
// rtl/sl_wb_mon_pkg.sv - shared types and helpers for the Wishbone trace monitor
package sl_wb_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_TOUT = 2'd2
    } mon_state_t;

    // Increment v but hold at the all-ones value of a w-bit field (w <= 32)
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sl_sync_fifo.sv
// rtl/sl_sync_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers
module sl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign do_push = push & (~full | do_pop);
    assign valid   = ~empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sl_wb_trace_mon.sv
// rtl/sl_wb_trace_mon.sv - passive Wishbone monitor with checks, counters and trace FIFO
module sl_wb_trace_mon
    import sl_wb_mon_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              SEL_W       = DATA_W / 8,
    parameter int              DEPTH       = 16,
    parameter int              TS_W        = 32,
    parameter int              LAT_W       = 8,
    parameter int              CNT_W       = 16,
    parameter int              TIMEOUT     = 255,
    parameter logic [ADDR_W-1:0] FINISH_ADDR = 32'hFFFF_FFF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [SEL_W-1:0]  wb_sel,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_dat_w,
    input  logic [DATA_W-1:0] wb_dat_r,
    input  logic              wb_ack,
    input  logic              wb_err,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [ADDR_W-1:0] tr_adr,
    output logic [DATA_W-1:0] tr_data,
    output logic              tr_we,
    output logic [SEL_W-1:0]  tr_sel,
    output logic              tr_err,
    output logic [TS_W-1:0]   tr_ts,
    output logic [LAT_W-1:0]  tr_lat,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              proto_err,
    output logic              timeout_err,
    output logic              finish,
    output logic [DATA_W-1:0] finish_data
);
    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic              err;
        logic [TS_W-1:0]   ts;
        logic [LAT_W-1:0]  lat;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    mon_state_t        state_q, state_d;
    logic [TS_W-1:0]   ts_q, ts_d, start_ts_q, start_ts_d;
    logic [LAT_W-1:0]  lat_q, lat_d, lat_inc;
    logic [ADDR_W-1:0] l_adr_q, l_adr_d;
    logic              l_we_q, l_we_d;
    logic [SEL_W-1:0]  l_sel_q, l_sel_d;
    logic [DATA_W-1:0] l_dat_q, l_dat_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
    logic              proto_q, proto_d, tout_q, tout_d, fin_q, fin_d;
    logic [DATA_W-1:0] fin_data_q, fin_data_d;

    logic              req, done, lat_hit, chg, push, fifo_full;
    entry_t            ent, head, held;
    logic [ENTRY_W-1:0] fifo_rdata;

    assign req     = wb_cyc & wb_stb;
    assign done    = req & (wb_ack | wb_err);
    assign lat_inc = LAT_W'(sat_inc(32'(lat_q), LAT_W));
    assign lat_hit = 32'(lat_inc) >= 32'(TIMEOUT);
    assign chg     = (wb_adr != l_adr_q) | (wb_we != l_we_q) | (wb_sel != l_sel_q) | (wb_dat_w != l_dat_q);

    // Entry built from the request captured at its start, for multi-cycle completions
    always_comb begin
        held      = '0;
        held.adr  = l_adr_q;
        held.data = l_we_q ? l_dat_q : wb_dat_r;
        held.we   = l_we_q;
        held.sel  = l_sel_q;
        held.err  = wb_err;
        held.ts   = start_ts_q;
        held.lat  = lat_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req && !done) state_d = ST_PEND;
            ST_PEND: begin
                if (done || !req)  state_d = ST_IDLE;
                else if (lat_hit)  state_d = ST_TOUT;
            end
            ST_TOUT: if (done || !req) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture, trace entry, checks, counters and flags
    always_comb begin
        ts_d       = ts_q + 1'b1;
        start_ts_d = start_ts_q;
        lat_d      = lat_q;
        l_adr_d    = l_adr_q;
        l_we_d     = l_we_q;
        l_sel_d    = l_sel_q;
        l_dat_d    = l_dat_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        proto_d    = proto_q;
        tout_d     = tout_q;
        fin_d      = fin_q;
        fin_data_d = fin_data_q;
        push       = 1'b0;
        ent        = '0;

        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    push     = 1'b1;
                    ent.adr  = wb_adr;
                    ent.data = wb_we ? wb_dat_w : wb_dat_r;
                    ent.we   = wb_we;
                    ent.sel  = wb_sel;
                    ent.err  = wb_err;
                    ent.ts   = ts_q;
                    ent.lat  = '0;
                end else if (req) begin
                    l_adr_d    = wb_adr;
                    l_we_d     = wb_we;
                    l_sel_d    = wb_sel;
                    l_dat_d    = wb_dat_w;
                    start_ts_d = ts_q;
                    lat_d      = LAT_W'(1);
                end
            end
            ST_PEND: begin
                if (req && chg) proto_d = 1'b1;
                if (done) begin
                    push = 1'b1;
                    ent  = held;
                end else if (!req) begin
                    proto_d = 1'b1;
                end else begin
                    lat_d = lat_inc;
                    if (lat_hit) tout_d = 1'b1;
                end
            end
            ST_TOUT: begin
                if (done) begin
                    push    = 1'b1;
                    ent     = held;
                    ent.err = 1'b1;
                    ent.lat = '1;
                end
            end
            default: ;
        endcase

        if (wb_stb && !wb_cyc)            proto_d = 1'b1;
        if ((wb_ack || wb_err) && !req)   proto_d = 1'b1;
        if (wb_ack && wb_err)             proto_d = 1'b1;

        if (push) begin
            if (ent.we) wr_cnt_d = CNT_W'(sat_inc(32'(wr_cnt_q), CNT_W));
            else        rd_cnt_d = CNT_W'(sat_inc(32'(rd_cnt_q), CNT_W));
            if (wb_err) err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
            if (fifo_full && !tr_ready) drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
            if (ent.we && ent.adr == FINISH_ADDR) begin
                fin_d      = 1'b1;
                fin_data_d = ent.data;
            end
        end

        if (clr) begin
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            err_cnt_d  = '0;
            drop_cnt_d = '0;
            proto_d    = 1'b0;
            tout_d     = 1'b0;
            fin_d      = 1'b0;
            fin_data_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q       <= '0;
            start_ts_q <= '0;
            lat_q      <= '0;
            l_adr_q    <= '0;
            l_we_q     <= 1'b0;
            l_sel_q    <= '0;
            l_dat_q    <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            proto_q    <= 1'b0;
            tout_q     <= 1'b0;
            fin_q      <= 1'b0;
            fin_data_q <= '0;
        end else begin
            ts_q       <= ts_d;
            start_ts_q <= start_ts_d;
            lat_q      <= lat_d;
            l_adr_q    <= l_adr_d;
            l_we_q     <= l_we_d;
            l_sel_q    <= l_sel_d;
            l_dat_q    <= l_dat_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            proto_q    <= proto_d;
            tout_q     <= tout_d;
            fin_q      <= fin_d;
            fin_data_q <= fin_data_d;
        end
    end

    sl_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (ent),
        .pop   (tr_ready),
        .rdata (fifo_rdata),
        .valid (tr_valid),
        .full  (fifo_full)
    );

    // Head fields read as zero while the FIFO is empty
    assign head        = fifo_rdata;
    assign tr_adr      = tr_valid ? head.adr  : '0;
    assign tr_data     = tr_valid ? head.data : '0;
    assign tr_we       = tr_valid & head.we;
    assign tr_sel      = tr_valid ? head.sel  : '0;
    assign tr_err      = tr_valid & head.err;
    assign tr_ts       = tr_valid ? head.ts   : '0;
    assign tr_lat      = tr_valid ? head.lat  : '0;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign proto_err   = proto_q;
    assign timeout_err = tout_q;
    assign finish      = fin_q;
    assign finish_data = fin_data_q;

endmodule

// File: tb/tb_sl_wb_trace_mon.sv
// tb/tb_sl_wb_trace_mon.sv - self-checking bench for sl_wb_trace_mon
module tb_sl_wb_trace_mon;
    localparam int CNT_W = 5;
    localparam int CMAX  = 31;
    localparam logic [31:0] FIN_A = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic        tr_valid, tr_ready, tr_we, tr_err;
    logic [31:0] tr_adr, tr_data, tr_ts;
    logic [3:0]  tr_sel;
    logic [7:0]  tr_lat;
    logic [CNT_W-1:0] rd_cnt, wr_cnt, err_cnt, drop_cnt;
    logic        proto_err, timeout_err, finish;
    logic [31:0] finish_data;

    sl_wb_trace_mon #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_adr(tr_adr), .tr_data(tr_data),
        .tr_we(tr_we), .tr_sel(tr_sel), .tr_err(tr_err), .tr_ts(tr_ts), .tr_lat(tr_lat),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt),
        .proto_err(proto_err), .timeout_err(timeout_err),
        .finish(finish), .finish_data(finish_data)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; equals the timestamp a request started at
    logic [31:0] tb_ts;
    always @(posedge clk) tb_ts <= !rst ? 32'd0 : tb_ts + 32'd1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] ts;
        logic [7:0]  lat;
    } exp_t;

    exp_t q[$];
    int   m_rd, m_wr, m_err, m_drop;
    bit   m_fin, m_proto, m_tout;
    logic [31:0] m_fin_data;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_clear_counters();
        m_rd = 0; m_wr = 0; m_err = 0; m_drop = 0;
        m_fin = 0; m_fin_data = 0; m_proto = 0; m_tout = 0;
    endtask

    task automatic chk_cnts(input string tag);
        check({tag, ".rd_cnt"}, rd_cnt, sat(m_rd));
        check({tag, ".wr_cnt"}, wr_cnt, sat(m_wr));
        check({tag, ".err_cnt"}, err_cnt, sat(m_err));
        check({tag, ".drop_cnt"}, drop_cnt, sat(m_drop));
        check({tag, ".finish"}, finish, m_fin);
        check({tag, ".finish_data"}, finish_data, m_fin_data);
        check({tag, ".proto_err"}, proto_err, m_proto);
        check({tag, ".timeout_err"}, timeout_err, m_tout);
    endtask

    task automatic chk_head(input string tag);
        check({tag, ".valid"}, tr_valid, 1'b1);
        check({tag, ".adr"}, tr_adr, q[0].adr);
        check({tag, ".data"}, tr_data, q[0].data);
        check({tag, ".we"}, tr_we, q[0].we);
        check({tag, ".sel"}, tr_sel, q[0].sel);
        check({tag, ".err"}, tr_err, q[0].err);
        check({tag, ".ts"}, tr_ts, q[0].ts);
        check({tag, ".lat"}, tr_lat, q[0].lat);
    endtask

    task automatic model_log(input exp_t x);
        if (q.size() < 16) q.push_back(x);
        else m_drop++;
        if (x.we) m_wr++; else m_rd++;
        if (x.we && x.adr == FIN_A) begin
            m_fin = 1; m_fin_data = x.data;
        end
    endtask

    task automatic drain(input string tag);
        exp_t tmp;
        int   n;
        n = q.size();
        for (int i = 0; i < n; i++) begin
            chk_head(tag);
            tr_ready = 1'b1;
            @(negedge clk);
            tr_ready = 1'b0;
            tmp = q.pop_front();
        end
        check({tag, ".empty"}, tr_valid, 1'b0);
    endtask

    task automatic idle_bus();
        wb_cyc = 0; wb_stb = 0; wb_ack = 0; wb_err = 0;
    endtask

    // One transaction: completion wt cycles after the request starts
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int wt, input bit e, input bit both,
                        input bit rdy);
        exp_t        x;
        exp_t        tmp;
        logic [31:0] rd;
        rd = $urandom;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
        wb_dat_r = $urandom; wb_ack = 0; wb_err = 0;
        x.ts = tb_ts;
        for (int i = 0; i < wt; i++) @(negedge clk);
        wb_dat_r = rd; wb_ack = !e | both; wb_err = e;
        if (rdy) begin
            tr_ready = 1'b1;
            if (q.size() > 0) begin
                chk_head("pop_on_push");
                tmp = q.pop_front();
            end
        end
        @(negedge clk);
        idle_bus();
        tr_ready = 1'b0;
        x.adr = adr; x.data = we ? dat : rd; x.we = we; x.sel = sel;
        x.err = e; x.lat = 8'(wt);
        if (e) m_err++;
        model_log(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t x;
        logic [31:0] rd;
        rst = 0; clr = 0; tr_ready = 0;
        wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat_w = 0; wb_dat_r = 0;
        idle_bus();
        model_clear_counters();
        repeat (3) @(negedge clk);
        check("reset.valid", tr_valid, 1'b0);
        check("reset.adr", tr_adr, 0);
        check("reset.lat", tr_lat, 0);
        chk_cnts("reset");
        rst = 1;
        @(negedge clk);

        // Simple read with three wait cycles
        xfer(0, 32'h100, 4'hF, 32'h0, 3, 0, 0, 0);
        chk_cnts("read");
        drain("read");

        // Zero-wait finish write
        xfer(1, FIN_A, 4'hF, 32'hDEAD, 0, 0, 0, 0);
        chk_cnts("finish");
        drain("finish");

        // Overfill, then a push coinciding with a pop while full
        for (int i = 0; i < 20; i++) xfer(1, 32'(i), 4'hF, $urandom, 0, 0, 0, 0);
        chk_cnts("overfill");
        xfer(1, 32'h1000, 4'h3, 32'h1234, 0, 0, 0, 1);
        chk_cnts("full_pop");
        drain("overfill");

        // Randomized traffic with periodic draining
        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                 $urandom_range(0, 4), ($urandom_range(0, 3) == 0), 0, 0);
            if (q.size() >= 8 || $urandom_range(0, 4) == 0) drain("rand");
        end
        chk_cnts("rand");
        drain("rand_end");

        // Watchdog expiry and late ack
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h200; wb_sel = 4'hF; wb_dat_w = 0;
        x.ts = tb_ts;
        repeat (254) @(negedge clk);
        check("tout.before", timeout_err, 1'b0);
        @(negedge clk);
        check("tout.at", timeout_err, 1'b1);
        m_tout = 1;
        rd = $urandom;
        wb_dat_r = rd; wb_ack = 1;
        @(negedge clk);
        idle_bus();
        x.adr = 32'h200; x.data = rd; x.we = 0; x.sel = 4'hF; x.err = 1; x.lat = 8'hFF;
        model_log(x);
        chk_cnts("tout");
        drain("tout");

        // Address change during a pending request
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h300; wb_sel = 4'hF; wb_dat_w = 0;
        x.ts = tb_ts;
        @(negedge clk);
        wb_adr = 32'h304;
        @(negedge clk);
        rd = $urandom;
        wb_dat_r = rd; wb_ack = 1;
        @(negedge clk);
        idle_bus();
        x.adr = 32'h300; x.data = rd; x.we = 0; x.sel = 4'hF; x.err = 0; x.lat = 8'd2;
        model_log(x);
        m_proto = 1;
        chk_cnts("adr_chg");
        clr = 1; @(negedge clk); clr = 0;
        model_clear_counters();
        chk_cnts("clr1");
        // Stray ack with no cycle
        wb_ack = 1; @(negedge clk); wb_ack = 0;
        m_proto = 1;
        chk_cnts("stray_ack");
        // ack and err together: still logged, as an error
        xfer(1, 32'h310, 4'h1, 32'h55, 0, 1, 1, 0);
        m_proto = 1;
        chk_cnts("ack_err");
        clr = 1; @(negedge clk); clr = 0;
        model_clear_counters();
        chk_cnts("clr2");
        drain("after_clr");

        // Reset in the middle of a pending request
        xfer(1, 32'h380, 4'hF, 32'h77, 1, 0, 0, 0);
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h400; wb_sel = 4'hF;
        repeat (2) @(negedge clk);
        rst = 0; idle_bus();
        repeat (2) @(negedge clk);
        rst = 1;
        q.delete();
        model_clear_counters();
        check("rst_mid.valid", tr_valid, 1'b0);
        chk_cnts("rst_mid");
        xfer(0, 32'h500, 4'hF, 32'h0, 1, 0, 0, 0);
        chk_cnts("after_rst");
        drain("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
